heart_rate_calculator: RTL and testbench
========================================

Name: heart_rate_calculator

Overview:
Consumes the one-bit peak_detected stream from the peak detector and measures the interval between accepted beats. It keeps a running average of the last AVG_DEPTH intervals and converts it to beats per minute with a sequential divider. Its outputs are bpm, a one-cycle bpm_valid strobe, a beat strobe and a loss-of-signal flag. It sits downstream of peak detection and feeds the display/alarm logic.

Parameters:
- SAMPLE_RATE, 256: samples per second; one sample per clk cycle.
- REFRACTORY, 64: minimum interval in cycles between accepted beats (250 ms). Must be greater than NUM_W+2.
- TIMEOUT, 768: interval in cycles after which the signal is declared lost (3 s).
- AVG_DEPTH, 4: intervals averaged; power of two, at least 2.
- CNT_W, 12: interval counter width; must hold TIMEOUT.
- BPM_W, 8: output width.

Ports:
- clk, input, 1: sample clock.
- rst, input, 1: asynchronous, active-low reset. All state clears while rst is 0.
- peak_detected, input, 1: level from the peak detector; may stay high for several cycles.
- bpm, output, BPM_W: last computed rate; holds between updates.
- bpm_valid, output, 1: one-cycle strobe when bpm updates.
- beat, output, 1: one-cycle strobe per accepted beat.
- no_signal, output, 1: level flag; high after timeout or reset until the second accepted beat.
- busy, output, 1: divider running.

Behaviour:
- Reset values: bpm=0, bpm_valid=0, beat=0, no_signal=1, busy=0. Also cnt=0, armed=0, fill=0, sum=0, all buffer entries 0, divider in IDLE.
- Edge detect: peak_q registers peak_detected. edge = peak_detected & ~peak_q. A held-high level yields exactly one edge.
- cnt increments every cycle and saturates at TIMEOUT.
- Edge while armed=0: accepted. Set armed=1, cnt<=1, no interval pushed.
- Edge while armed=1 and cnt>=REFRACTORY: accepted. interval=cnt is pushed, then cnt<=1. The interval equals the cycle distance between the two edges.
- Edge while armed=1 and cnt<REFRACTORY: ignored, and cnt keeps counting.
- beat: high in cycle T+1 for an edge accepted at posedge T.
- Push:
  - sum <= sum - buf[wr] + interval; buf[wr] <= interval; wr wraps modulo AVG_DEPTH.
  - fill saturates at AVG_DEPTH.
  - The first push clears no_signal.
- Divide: quotient = (60*SAMPLE_RATE*fill) / sum.
  - Unsigned, truncating. NUM_W = clog2(60*SAMPLE_RATE*AVG_DEPTH+1).
  - The quotient saturates to 2^BPM_W-1.
  - Using fill in the numerator gives an exact average before the buffer is full.
- Divider FSM:
  - IDLE -> DIVIDE in the cycle after a push.
  - DIVIDE: restoring, one quotient bit per cycle for NUM_W cycles.
  - DIVIDE -> DONE; in DONE, bpm is written and bpm_valid pulses; then -> IDLE.
  - busy = (state != IDLE).
- Latency: for an edge sampled at posedge T (push), bpm_valid is high in cycle T+NUM_W+2. That is T+18 at defaults.
- Timeout: when armed and cnt reaches TIMEOUT:
  - Set armed=0, fill=0, sum=0, all buf entries=0, bpm=0, no_signal=1.
  - Abort the divider to IDLE with no bpm_valid.
  - The next edge re-arms.
- A push cannot occur in DIVIDE because REFRACTORY > NUM_W+2. The bench asserts this.
- Simultaneous timeout and edge in the same cycle: timeout wins, and the edge re-arms (armed=1, cnt<=1).
- Reset mid-divide: outputs take reset values asynchronously, and no bpm_valid appears after release.

Decomposition:
- Package hr_pkg: NUM_W derivation function, the BPM_SCALE = 60*SAMPLE_RATE constant, and the divider state enum (IDLE, DIVIDE, DONE).
- Sub-module seq_divider: parameterised width, start/done handshake, abort input, restoring algorithm.
- Interval counter, averaging buffer and control stay in the top module.

Test Plan:
- Edges every 256 cycles, 5 beats. First bpm_valid reports 60, 18 cycles after the second edge. All later updates report 60. no_signal drops after the second edge.
- Intervals 256 then 128: after the second push, bpm = 30720/384 = 80. Steady 128-cycle intervals converge to 120 once fill=4.
- Glitch edge 30 cycles after a beat: no beat strobe, no push. The next true edge 256 cycles after the beat gives interval 256 and bpm 60.
- peak_detected held high for 10 cycles: exactly one beat pulse.
- No edge for 768 cycles after a beat: no_signal=1, bpm=0, busy=0. The next two edges 192 apart give bpm 80 with fill=1.
- Assert rst 5 cycles into DIVIDE: immediate reset values. No bpm_valid follows after release until two new edges arrive.

Source files
------------

// File: rtl/hr_pkg.sv
// Shared definitions for the heart-rate calculator and its divider.
// Latency: n/a (constants, types and elaboration-time helpers only).
// Backpressure: n/a.
package hr_pkg;

  localparam int SEC_PER_MIN = 60;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } div_state_t;

  // Samples per minute: the numerator scale that turns an average interval into BPM.
  function automatic int bpm_scale(input int sample_rate);
    return SEC_PER_MIN * sample_rate;
  endfunction

  // Divider width: must hold the largest numerator, BPM_SCALE * AVG_DEPTH.
  function automatic int num_w(input int sample_rate, input int avg_depth);
    return $clog2(bpm_scale(sample_rate) * avg_depth + 1);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Latency: start sampled in IDLE does bit 1, W-1 more cycles in DIVIDE, then one cycle in DONE.
// Backpressure: none; start is ignored unless IDLE, abort returns to IDLE at once.
// Ports: clk, rst (async active-low), i_start, i_abort, i_dividend, i_divisor,
//        o_busy (state != IDLE), o_done (high while in DONE), o_quot (valid in DONE).
module seq_divider
  import hr_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_quot
);

  localparam int CW = $clog2(W + 1);

  div_state_t    r_state;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quot;
  logic [W-1:0]  r_div;
  logic [CW-1:0] r_cnt;

  logic [W-1:0]  w_src_rem;
  logic [W-1:0]  w_src_quot;
  logic [W-1:0]  w_src_div;
  logic [W:0]    w_shift;
  logic          w_ge;
  logic [W-1:0]  w_rem_nxt;
  logic [W-1:0]  w_quot_nxt;

  // One restoring step. In IDLE the step runs on the fresh operands so the
  // load cycle already produces the first quotient bit.
  always_comb begin
    w_src_rem  = (r_state == IDLE) ? '0         : r_rem;
    w_src_quot = (r_state == IDLE) ? i_dividend : r_quot;
    w_src_div  = (r_state == IDLE) ? i_divisor  : r_div;
    w_shift    = {w_src_rem, w_src_quot[W-1]};
    w_ge       = (w_shift >= {1'b0, w_src_div});
    // Partial remainder is always below the divisor, so W bits suffice.
    w_rem_nxt  = w_ge ? W'(w_shift - {1'b0, w_src_div}) : W'(w_shift);
    w_quot_nxt = {w_src_quot[W-2:0], w_ge};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_quot  <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
    end else if (i_abort) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_rem   <= w_rem_nxt;
            r_quot  <= w_quot_nxt;
            r_div   <= i_divisor;
            r_cnt   <= CW'(1);
            r_state <= DIVIDE;
          end
        end
        DIVIDE: begin
          r_rem  <= w_rem_nxt;
          r_quot <= w_quot_nxt;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(W - 1)) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != IDLE);
  assign o_done = (r_state == DONE);
  assign o_quot = r_quot;

endmodule

// File: rtl/heart_rate_calculator.sv
// Beat interval measurement, running average over AVG_DEPTH intervals, BPM via sequential divide.
// Latency: beat one cycle after the accepted edge; bpm_valid NUM_W+2 cycles after a push.
// Backpressure: none; the refractory window guarantees the divider is idle at every push.
// Ports: clk, rst (async active-low), peak_detected (level);
//        bpm, bpm_valid (strobe), beat (strobe), no_signal (level), busy (divider running).
module heart_rate_calculator
  import hr_pkg::*;
#(
  parameter int SAMPLE_RATE = 256,
  parameter int REFRACTORY  = 64,
  parameter int TIMEOUT     = 768,
  parameter int AVG_DEPTH   = 4,
  parameter int CNT_W       = 12,
  parameter int BPM_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             peak_detected,
  output logic [BPM_W-1:0] bpm,
  output logic             bpm_valid,
  output logic             beat,
  output logic             no_signal,
  output logic             busy
);

  localparam int BPM_SCALE = bpm_scale(SAMPLE_RATE);
  localparam int NUM_W     = num_w(SAMPLE_RATE, AVG_DEPTH);
  localparam int PTR_W     = $clog2(AVG_DEPTH);
  localparam int FILL_W    = PTR_W + 1;
  localparam int SUM_W     = CNT_W + PTR_W;

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_REFR = CNT_W'(REFRACTORY);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(AVG_DEPTH);
  localparam logic [NUM_W-1:0]  QUOT_MAX = NUM_W'(2 ** BPM_W - 1);

  logic              r_peak_q;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_armed;
  logic [CNT_W-1:0]  r_buf [AVG_DEPTH];
  logic [PTR_W-1:0]  r_wr;
  logic [FILL_W-1:0] r_fill;
  logic [SUM_W-1:0]  r_sum;
  logic              r_push_q;
  logic [BPM_W-1:0]  r_bpm;
  logic              r_bpm_valid;
  logic              r_beat;
  logic              r_no_signal;

  logic              w_edge;
  logic              w_timeout;
  logic              w_past_refr;
  logic              w_accept;
  logic              w_push;
  logic [NUM_W-1:0]  w_dividend;
  logic [NUM_W-1:0]  w_divisor;
  logic [NUM_W-1:0]  w_quot;
  logic              w_div_done;
  logic              w_div_busy;
  logic [BPM_W-1:0]  w_bpm_sat;

  assign w_edge      = peak_detected & ~r_peak_q;
  assign w_timeout   = r_armed & (r_cnt == CNT_MAX);
  assign w_past_refr = (r_cnt >= CNT_REFR);
  assign w_accept    = w_edge & (~r_armed | w_past_refr);
  // Timeout has priority: an edge on the timeout cycle only re-arms.
  assign w_push      = w_edge & r_armed & w_past_refr & ~w_timeout;

  // Scaling by fill keeps the average exact while the buffer is still filling.
  assign w_dividend  = NUM_W'(BPM_SCALE * int'(r_fill));
  assign w_divisor   = NUM_W'(r_sum);
  assign w_bpm_sat   = (w_quot > QUOT_MAX) ? {BPM_W{1'b1}} : w_quot[BPM_W-1:0];

  // Operands are taken the cycle after the push, once fill/sum hold the new interval.
  seq_divider #(.W(NUM_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (r_push_q),
    .i_abort    (w_timeout),
    .i_dividend (w_dividend),
    .i_divisor  (w_divisor),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quot     (w_quot)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_peak_q    <= 1'b0;
      r_cnt       <= '0;
      r_armed     <= 1'b0;
      r_wr        <= '0;
      r_fill      <= '0;
      r_sum       <= '0;
      r_push_q    <= 1'b0;
      r_bpm       <= '0;
      r_bpm_valid <= 1'b0;
      r_beat      <= 1'b0;
      r_no_signal <= 1'b1;
      for (int i = 0; i < AVG_DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_peak_q    <= peak_detected;
      r_push_q    <= w_push;
      r_beat      <= 1'b0;
      r_bpm_valid <= 1'b0;
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);

      if (w_timeout) begin
        r_armed     <= 1'b0;
        r_wr        <= '0;
        r_fill      <= '0;
        r_sum       <= '0;
        r_bpm       <= '0;
        r_no_signal <= 1'b1;
        for (int i = 0; i < AVG_DEPTH; i++) r_buf[i] <= '0;
        if (w_edge) begin
          r_armed <= 1'b1;
          r_cnt   <= CNT_W'(1);
          r_beat  <= 1'b1;
        end
      end else begin
        if (w_accept) begin
          r_armed <= 1'b1;
          r_cnt   <= CNT_W'(1);
          r_beat  <= 1'b1;
        end
        if (w_push) begin
          // The pre-edge count is exactly the distance between the two edges.
          r_sum       <= r_sum - SUM_W'(r_buf[r_wr]) + SUM_W'(r_cnt);
          r_buf[r_wr] <= r_cnt;
          r_wr        <= r_wr + PTR_W'(1);
          if (r_fill != FILL_MAX) r_fill <= r_fill + FILL_W'(1);
          r_no_signal <= 1'b0;
        end
        if (w_div_done) begin
          r_bpm       <= w_bpm_sat;
          r_bpm_valid <= 1'b1;
        end
      end
    end
  end

  assign bpm       = r_bpm;
  assign bpm_valid = r_bpm_valid;
  assign beat      = r_beat;
  assign no_signal = r_no_signal;
  assign busy      = w_div_busy;

endmodule

// File: tb/tb_heart_rate_calculator.sv
// Self-checking bench for heart_rate_calculator at default parameters.
// Expected BPM values come from a behavioural beat/interval model and are queued per push.
// A negedge monitor pops the queue on every bpm_valid and checks value and arrival cycle.
module tb_heart_rate_calculator;

  localparam int BPM_SCALE = 15360;
  localparam int REFR      = 64;
  localparam int TMO       = 768;
  localparam int DEPTH     = 4;
  localparam int LAT       = 17;  // posedges from the push edge to the one raising bpm_valid

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       peak_detected = 1'b0;
  logic [7:0] bpm;
  logic       bpm_valid;
  logic       beat;
  logic       no_signal;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int exp_bpm_q[$];
  int exp_cyc_q[$];
  int mon_b, mon_c;

  bit m_armed = 1'b0;
  int m_last  = 0;
  int m_iv[$];

  heart_rate_calculator dut (
    .clk           (clk),
    .rst           (rst),
    .peak_detected (peak_detected),
    .bpm           (bpm),
    .bpm_valid     (bpm_valid),
    .beat          (beat),
    .no_signal     (no_signal),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every bpm_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && bpm_valid) begin
      if (exp_bpm_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_bpm_valid cyc=%0d bpm=%0d", cyc, bpm);
      end else begin
        mon_b = exp_bpm_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        n_tests++;
        if (int'(bpm) !== mon_b) begin
          n_fail++;
          $display("FAIL bpm_value cyc=%0d got=%0d exp=%0d", cyc, bpm, mon_b);
        end
        n_tests++;
        if (cyc !== mon_c) begin
          n_fail++;
          $display("FAIL bpm_latency got_cyc=%0d exp_cyc=%0d", cyc, mon_c);
        end
      end
    end
    // A push while the divider runs would show as a beat strobe during busy.
    if (rst && beat && busy) begin
      n_fail++;
      $display("FAIL push_in_divide cyc=%0d beat=%b busy=%b", cyc, beat, busy);
    end
  end

  task automatic model_clear();
    m_armed = 1'b0;
    m_iv.delete();
    exp_bpm_q.delete();
    exp_cyc_q.delete();
  endtask

  // Raise peak_detected so its rising edge is sampled at posedge 'target', hold 'width' cycles.
  task automatic fire(input int target, input int width, output int n_beats);
    int  e;
    int  s;
    int  eb;
    bit  exp_beat;
    while (cyc < target - 1) @(negedge clk);
    e        = cyc + 1;
    exp_beat = 1'b0;
    if (m_armed && (e - m_last >= TMO)) begin
      m_armed = 1'b0;
      m_iv.delete();
    end
    if (!m_armed) begin
      m_armed  = 1'b1;
      m_last   = e;
      exp_beat = 1'b1;
    end else if (e - m_last >= REFR) begin
      m_iv.push_back(e - m_last);
      if (m_iv.size() > DEPTH) void'(m_iv.pop_front());
      s = 0;
      foreach (m_iv[k]) s += m_iv[k];
      eb = (BPM_SCALE * m_iv.size()) / s;
      if (eb > 255) eb = 255;
      exp_bpm_q.push_back(eb);
      exp_cyc_q.push_back(e + LAT);
      m_last   = e;
      exp_beat = 1'b1;
    end
    n_beats = 0;
    peak_detected = 1'b1;
    for (int i = 0; i < width; i++) begin
      @(posedge clk);
      #1;
      if (beat === 1'b1) n_beats++;
      n_tests++;
      if (beat !== ((i == 0) ? exp_beat : 1'b0)) begin
        n_fail++;
        $display("FAIL beat_strobe cyc=%0d got=%b exp=%b", cyc, beat, (i == 0) ? exp_beat : 1'b0);
      end
      @(negedge clk);
    end
    peak_detected = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || exp_bpm_q.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (k >= 100) begin
      n_fail++;
      $display("FAIL wait_idle_timeout busy=%b pending=%0d", busy, exp_bpm_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++; if (bpm !== 8'd0)      begin n_fail++; $display("FAIL reset_bpm got=%0d exp=0", bpm); end
    n_tests++; if (bpm_valid !== 1'b0) begin n_fail++; $display("FAIL reset_bpm_valid got=%b exp=0", bpm_valid); end
    n_tests++; if (beat !== 1'b0)      begin n_fail++; $display("FAIL reset_beat got=%b exp=0", beat); end
    n_tests++; if (no_signal !== 1'b1) begin n_fail++; $display("FAIL reset_no_signal got=%b exp=1", no_signal); end
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_steady_60();
    int base, nb;
    base = cyc + 5;
    fire(base, 1, nb);
    n_tests++; if (no_signal !== 1'b1) begin n_fail++; $display("FAIL steady_nosig_first got=%b exp=1", no_signal); end
    fire(base + 256, 1, nb);
    n_tests++; if (no_signal !== 1'b0) begin n_fail++; $display("FAIL steady_nosig_second got=%b exp=0", no_signal); end
    for (int i = 2; i < 5; i++) fire(base + 256 * i, 1, nb);
    wait_idle();
    n_tests++; if (bpm !== 8'd60) begin n_fail++; $display("FAIL steady_bpm got=%0d exp=60", bpm); end
  endtask

  task automatic test_avg_convergence();
    int base, nb;
    do_reset();
    base = cyc + 5;
    fire(base, 1, nb);
    fire(base + 256, 1, nb);
    fire(base + 384, 1, nb);
    wait_idle();
    n_tests++; if (bpm !== 8'd80) begin n_fail++; $display("FAIL avg_80 got=%0d exp=80", bpm); end
    for (int i = 1; i <= 4; i++) fire(base + 384 + 128 * i, 1, nb);
    wait_idle();
    n_tests++; if (bpm !== 8'd120) begin n_fail++; $display("FAIL avg_120 got=%0d exp=120", bpm); end
  endtask

  task automatic test_glitch();
    int base, nb;
    do_reset();
    base = cyc + 5;
    fire(base, 1, nb);
    fire(base + 256, 1, nb);
    fire(base + 286, 1, nb);
    n_tests++; if (nb !== 0) begin n_fail++; $display("FAIL glitch_beat got=%0d exp=0", nb); end
    fire(base + 512, 1, nb);
    wait_idle();
    n_tests++; if (bpm !== 8'd60) begin n_fail++; $display("FAIL glitch_bpm got=%0d exp=60", bpm); end
  endtask

  task automatic test_held_high();
    int nb;
    fire(m_last + 200, 10, nb);
    n_tests++; if (nb !== 1) begin n_fail++; $display("FAIL held_high_beats got=%0d exp=1", nb); end
    wait_idle();
  endtask

  task automatic test_timeout();
    int base, nb;
    while (cyc < m_last + 800) @(negedge clk);
    n_tests++; if (no_signal !== 1'b1) begin n_fail++; $display("FAIL timeout_nosig got=%b exp=1", no_signal); end
    n_tests++; if (bpm !== 8'd0)       begin n_fail++; $display("FAIL timeout_bpm got=%0d exp=0", bpm); end
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL timeout_busy got=%b exp=0", busy); end
    base = cyc + 5;
    fire(base, 1, nb);
    n_tests++; if (no_signal !== 1'b1) begin n_fail++; $display("FAIL timeout_rearm_nosig got=%b exp=1", no_signal); end
    fire(base + 192, 1, nb);
    wait_idle();
    n_tests++; if (bpm !== 8'd80)      begin n_fail++; $display("FAIL timeout_bpm80 got=%0d exp=80", bpm); end
    n_tests++; if (no_signal !== 1'b0) begin n_fail++; $display("FAIL timeout_nosig_clear got=%b exp=0", no_signal); end
  endtask

  task automatic test_reset_mid_divide();
    int base, nb;
    fire(m_last + 300, 1, nb);
    repeat (5) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL middiv_busy_before got=%b exp=1", busy); end
    rst = 1'b0;
    model_clear();
    #1;
    n_tests++; if (bpm !== 8'd0)       begin n_fail++; $display("FAIL middiv_bpm got=%0d exp=0", bpm); end
    n_tests++; if (bpm_valid !== 1'b0) begin n_fail++; $display("FAIL middiv_bpm_valid got=%b exp=0", bpm_valid); end
    n_tests++; if (no_signal !== 1'b1) begin n_fail++; $display("FAIL middiv_nosig got=%b exp=1", no_signal); end
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL middiv_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    n_tests++; if (bpm !== 8'd0) begin n_fail++; $display("FAIL middiv_after_bpm got=%0d exp=0", bpm); end
    base = cyc + 5;
    fire(base, 1, nb);
    fire(base + 160, 1, nb);
    wait_idle();
    n_tests++; if (bpm !== 8'd96) begin n_fail++; $display("FAIL middiv_new_bpm got=%0d exp=96", bpm); end
  endtask

  initial begin
    test_reset();
    test_steady_60();
    test_avg_convergence();
    test_glitch();
    test_held_high();
    test_timeout();
    test_reset_mid_divide();
    repeat (5) @(negedge clk);
    n_tests++;
    if (exp_bpm_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_bpm_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
